// File: rtl/exec_pkg.sv
// Shared definitions for the multi-cycle execute stage: ALU op codes,
// forwarding selects and the FSM state type.
package exec_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MUL   = 4'b1000;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } exec_state_t;

endpackage

// File: rtl/execute_mc_mul.sv
// Iterative shift-add multiplier: one partial product per step, N steps.
// product shows the accumulator value as it will be after the current step.
module mul_iter #(
    parameter int N     = 64,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         step,
    input  logic         abort,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] product
);

    logic [N-1:0]     acc;
    logic [N-1:0]     mcand;
    logic [N-1:0]     mplr;
    logic [CNT_W-1:0] cnt;

    assign product = mplr[0] ? acc + mcand : acc;
    assign done    = (cnt == CNT_W'(1));

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
        end else if (start) begin
            acc   <= '0;
            mcand <= a;
            mplr  <= b;
            cnt   <= CNT_W'(N);
        end else if (step) begin
            acc   <= product;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/execute_mc.sv
// LEGv8 execute stage with forwarding, internal EX/MEM register, flush/hold
// handshake and a multi-cycle multiplier that stalls upstream while busy.
module execute_mc
    import exec_pkg::*;
#(
    parameter int N     = 64,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [1:0]   ForwardA,
    input  logic [1:0]   ForwardB,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    input  logic [N-1:0] result_W,
    input  logic         flush_E,
    input  logic         hold_M,
    output logic         busy_E,
    output logic         valid_M,
    output logic [N-1:0] PCBranch_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] writeData_M,
    output logic         zero_M
);

    exec_state_t  state, state_next;
    logic [N-1:0] a_op, bf_op, b_op, alu_res, pc_branch, product;
    logic         is_mul, mul_start, mul_step, mul_abort, mul_done;
    logic         ex_load, mul_finish;

    assign is_mul    = valid_E && (AluControl == ALU_MUL);
    assign b_op      = AluSrc ? signImm_E : bf_op;
    assign pc_branch = PC_E + (signImm_E << 2);

    // Encoding 2'b11 falls through to register-file data.
    always_comb begin
        case (ForwardA)
            FWD_M:   a_op = aluResult_M;
            FWD_W:   a_op = result_W;
            default: a_op = readData1_E;
        endcase
        case (ForwardB)
            FWD_M:   bf_op = aluResult_M;
            FWD_W:   bf_op = result_W;
            default: bf_op = readData2_E;
        endcase
    end

    always_comb begin
        case (AluControl)
            ALU_AND:   alu_res = a_op & b_op;
            ALU_OR:    alu_res = a_op | b_op;
            ALU_ADD:   alu_res = a_op + b_op;
            ALU_SUB:   alu_res = a_op - b_op;
            ALU_PASSB: alu_res = b_op;
            ALU_NOR:   alu_res = ~(a_op | b_op);
            default:   alu_res = '0;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy_E     = 1'b0;
        mul_start  = 1'b0;
        mul_step   = 1'b0;
        mul_abort  = 1'b0;
        ex_load    = 1'b0;
        mul_finish = 1'b0;
        if (reset) begin
            state_next = IDLE;
        end else if (flush_E) begin
            state_next = IDLE;
            mul_abort  = 1'b1;
        end else if (hold_M) begin
            busy_E = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        busy_E     = 1'b1;
                        mul_start  = 1'b1;
                        state_next = MUL_BUSY;
                    end else begin
                        ex_load = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    mul_step = 1'b1;
                    if (mul_done) begin
                        mul_finish = 1'b1;
                        state_next = IDLE;
                    end else begin
                        busy_E = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A MUL issue parks PCBranch/writeData here; the product lands on the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_M     <= 1'b0;
            PCBranch_M  <= '0;
            aluResult_M <= '0;
            writeData_M <= '0;
            zero_M      <= 1'b0;
        end else if (flush_E) begin
            valid_M <= 1'b0;
        end else if (ex_load) begin
            valid_M     <= valid_E;
            PCBranch_M  <= pc_branch;
            aluResult_M <= alu_res;
            writeData_M <= bf_op;
            zero_M      <= (alu_res == '0);
        end else if (mul_start) begin
            valid_M     <= 1'b0;
            PCBranch_M  <= pc_branch;
            writeData_M <= bf_op;
        end else if (mul_finish) begin
            valid_M     <= 1'b1;
            aluResult_M <= product;
            zero_M      <= (product == '0);
        end
    end

    mul_iter #(.N(N), .CNT_W(CNT_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .step    (mul_step),
        .abort   (mul_abort),
        .a       (a_op),
        .b       (b_op),
        .done    (mul_done),
        .product (product)
    );

endmodule
